counter: RTL and testbench

- Parameterised synchronous binary counter, default 4 bits, free-running up-count with modulo wrap.
- Adds enable, synchronous clear, parallel load, up/down direction, terminal-count and wrap indications.
- General-purpose timing/sequence source for local control logic; single clock domain.

---
 rtl/counter_pkg.sv | 16 +
 rtl/counter_next.sv | 67 ++++++
 rtl/counter.sv | 66 ++++++
 tb/tb_counter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared constants and helpers for the counter block.
//   DEFAULT_WIDTH : default counter width in bits
//   max_val_for() : largest unsigned value representable in a given width
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // The shift is done in 64 bits so that a 32-bit counter does not overflow.
  function automatic int max_val_for(input int width);
    longint unsigned all_ones;
    all_ones = (64'd1 << width) - 64'd1;
    return int'(all_ones);
  endfunction

endpackage

// File: rtl/counter_next.sv
// counter_next
//   Combinational next-count and wrap-pulse logic for the counter.
//   Priority per edge: clr > load > en; with nothing active the count holds.
//   Ports:
//     count     in   current registered count
//     en        in   step enable
//     clr       in   clear to zero
//     load      in   parallel load (load_val clamped to MAX_VAL)
//     load_val  in   value to load
//     dir       in   0 = up, 1 = down
//     count_nxt out  value to register on the next edge
//     wrap_nxt  out  1 when this step wraps around a limit
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_VAL  = max_val_for(WIDTH),
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  output logic [WIDTH-1:0] count_nxt,
  output logic             wrap_nxt
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = (load_val > MAX_W) ? MAX_W : load_val;
    end else if (en) begin
      if (!dir) begin
        if (count >= MAX_W) begin
          // At the upper limit: wrap to zero or hold.
          if (SATURATE == 0) begin
            count_nxt = '0;
            wrap_nxt  = 1'b1;
          end else begin
            count_nxt = MAX_W;
          end
        end else begin
          count_nxt = count + ONE_W;
        end
      end else begin
        if (count == '0) begin
          // At zero: wrap to the upper limit or hold.
          if (SATURATE == 0) begin
            count_nxt = MAX_W;
            wrap_nxt  = 1'b1;
          end
        end else begin
          count_nxt = count - ONE_W;
        end
      end
    end
  end

endmodule

// File: rtl/counter.sv
// counter
//   Parameterised up/down counter with enable, synchronous clear, clamped
//   parallel load, terminal-count and wrap indications.
//   Ports:
//     clk       in   rising-edge clock
//     reset     in   asynchronous active-low reset
//     en        in   count enable
//     clr       in   synchronous clear
//     load      in   synchronous parallel load
//     load_val  in   load value (clamped to MAX_VAL)
//     dir       in   0 = up, 1 = down
//     count     out  registered count
//     tc        out  combinational terminal count for the current direction
//     wrap      out  registered one-cycle wrap pulse
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int MAX_VAL  = max_val_for(WIDTH),
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  counter_next #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_next (
    .count     (count),
    .en        (en),
    .clr       (clr),
    .load      (load),
    .load_val  (load_val),
    .dir       (dir),
    .count_nxt (count_nxt),
    .wrap_nxt  (wrap_nxt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

  assign tc = dir ? (count == '0) : (count == MAX_W);

endmodule

// File: tb/tb_counter.sv
// tb_counter
//   Drives three counter configurations (default wrap, saturating, 3-bit with
//   MAX_VAL=5) from shared inputs. A driver computes expected results with an
//   arithmetic reference model and queues them; a monitor compares after each
//   rising edge.
module tb_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, en, clr, load, dir;
  logic [3:0] load_val;

  logic [3:0] count_a, count_s;
  logic [2:0] count_w;
  logic       tc_a, tc_s, tc_w;
  logic       wrap_a, wrap_s, wrap_w;

  counter u_dflt (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .dir(dir), .count(count_a), .tc(tc_a), .wrap(wrap_a)
  );

  counter #(.SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load),
    .load_val(load_val), .dir(dir), .count(count_s), .tc(tc_s), .wrap(wrap_s)
  );

  counter #(.WIDTH(3), .MAX_VAL(5)) u_w3 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load),
    .load_val(load_val[2:0]), .dir(dir), .count(count_w), .tc(tc_w), .wrap(wrap_w)
  );

  typedef struct packed {
    logic [11:0] c;
    logic [2:0]  w;
    logic [2:0]  t;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;

  int m[3];
  int maxv[3] = '{15, 15, 5};
  bit sat[3]  = '{1'b0, 1'b1, 1'b0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one clock edge for every configuration.
  task automatic model_push();
    exp_t e;
    e = '0;
    for (int i = 0; i < 3; i++) begin
      int lv;
      bit w;
      lv = (i == 2) ? int'(load_val[2:0]) : int'(load_val);
      w  = 1'b0;
      if (!reset)     m[i] = 0;
      else if (clr)   m[i] = 0;
      else if (load)  m[i] = (lv > maxv[i]) ? maxv[i] : lv;
      else if (en) begin
        if (!dir) begin
          if (sat[i]) m[i] = (m[i] < maxv[i]) ? m[i] + 1 : m[i];
          else begin
            w    = (m[i] == maxv[i]);
            m[i] = (m[i] + 1) % (maxv[i] + 1);
          end
        end else begin
          if (sat[i]) m[i] = (m[i] > 0) ? m[i] - 1 : 0;
          else begin
            w    = (m[i] == 0);
            m[i] = (m[i] + maxv[i]) % (maxv[i] + 1);
          end
        end
      end
      e.c[4*i +: 4] = 4'(m[i]);
      e.w[i]        = w;
      e.t[i]        = dir ? (m[i] == 0) : (m[i] == maxv[i]);
    end
    q.push_back(e);
  endtask

  task automatic cycle(input bit r, input bit c, input bit l, input bit e,
                       input bit d, input logic [3:0] lv);
    @(negedge clk);
    reset = r; clr = c; load = l; en = e; dir = d; load_val = lv;
    model_push();
  endtask

  // Monitor: every clock edge the counters present a new result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("count_dflt", int'(count_a), int'(e.c[3:0]));
        chk("count_sat",  int'(count_s), int'(e.c[7:4]));
        chk("count_w3",   int'(count_w), int'(e.c[11:8]));
        chk("wrap_dflt",  int'(wrap_a),  int'(e.w[0]));
        chk("wrap_sat",   int'(wrap_s),  int'(e.w[1]));
        chk("wrap_w3",    int'(wrap_w),  int'(e.w[2]));
        chk("tc_dflt",    int'(tc_a),    int'(e.t[0]));
        chk("tc_sat",     int'(tc_s),    int'(e.t[1]));
        chk("tc_w3",      int'(tc_w),    int'(e.t[2]));
      end
    end
  end

  initial begin
    reset = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; dir = 1'b0; load_val = '0;
    m = '{0, 0, 0};
    #1;
    chk("reset_count_dflt", int'(count_a), 0);
    chk("reset_wrap_dflt",  int'(wrap_a), 0);

    // Reset held for two clocks, then count up through wrap.
    repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    repeat (20) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

    // Mid-run asynchronous reset between edges (default counter sits at 4).
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    #1;
    chk("async_reset_dflt", int'(count_a), 0);
    chk("async_reset_sat",  int'(count_s), 0);
    chk("async_reset_w3",   int'(count_w), 0);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

    // Priority: clr over load, load over en, then hold.
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9);
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Down-count from 2 into the lower limit.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);

    // Up-count from 14 into the upper limit.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd14);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

    // Load above the 3-bit counter's limit clamps to 5; then wrap 5->0.
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
    repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

    // Randomised operation.
    for (int k = 0; k < 400; k++) begin
      cycle(1'b1,
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0),
            4'($urandom_range(0, 15)));
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
